// File: rtl/coax_spi_pkg.sv
// coax_spi_pkg: command codes, FSM states and status byte layout for coax_spi_control.
package coax_spi_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'h03;
    localparam logic [7:0] CMD_RX     = 8'h05;
    localparam logic [7:0] CMD_TX     = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STATUS  = 3'd1,
        ST_RX_HI   = 3'd2,
        ST_RX_LO   = 3'd3,
        ST_TX_HI   = 3'd4,
        ST_TX_LO   = 3'd5,
        ST_DISCARD = 3'd6
    } state_e;

    localparam int STAT_RX_ACTIVE = 7;
    localparam int STAT_ERR       = 6;
    localparam int STAT_RX_EMPTY  = 5;
    localparam int STAT_TX_FULL   = 4;

    function automatic logic [7:0] status_byte(input logic rx_active, input logic err,
                                               input logic rx_empty, input logic full,
                                               input logic [3:0] version);
        logic [7:0] s;
        s                 = {4'd0, version};
        s[STAT_RX_ACTIVE] = rx_active;
        s[STAT_ERR]       = err;
        s[STAT_RX_EMPTY]  = rx_empty;
        s[STAT_TX_FULL]   = full;
        return s;
    endfunction

endpackage

// File: rtl/coax_spi_control_word_framer.sv
// coax_spi_word_framer: packs coax words into SPI hi/lo bytes and assembles TX words from byte pairs.
module coax_spi_word_framer #(
    parameter int DATA_WIDTH = 10
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  wempty,
    input  logic                  err,
    input  logic [7:0]            tx_hi,
    input  logic [7:0]            tx_lo,
    output logic [7:0]            hi_byte,
    output logic [7:0]            lo_byte,
    output logic [DATA_WIDTH-1:0] tx_word
);

    // an empty FIFO head carries no data: both bytes report zero payload
    assign hi_byte = {wempty, err, wempty ? 6'd0 : 6'(word >> 8)};
    assign lo_byte = wempty ? 8'd0 : word[7:0];
    assign tx_word = DATA_WIDTH'({tx_hi, tx_lo});

endmodule

// File: rtl/coax_spi_control.sv
// coax_spi_control: SPI command decoder framing coax RX/TX FIFO words as byte pairs,
// with status readback, sticky error/overflow flags and a soft-reset command.
module coax_spi_control
    import coax_spi_pkg::*;
#(
    parameter int         DATA_WIDTH     = 10,
    parameter logic [3:0] STATUS_VERSION = 4'h2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_cs,
    input  logic [7:0]            spi_rx_data,
    input  logic                  spi_rx_strobe,
    output logic [7:0]            spi_tx_data,
    input  logic                  rx_active,
    input  logic                  rx_error,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rx_read,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_load,
    input  logic                  tx_full,
    output logic                  soft_reset
);

    state_e                state;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  wempty_q;
    logic                  err_flag;
    logic                  ovf_flag;
    logic [7:0]            tx_hi_q;
    logic [DATA_WIDTH-1:0] fr_word;
    logic                  fr_empty;
    logic [7:0]            hi_byte;
    logic [7:0]            lo_byte;
    logic [DATA_WIDTH-1:0] tx_word;
    logic [7:0]            status;

    // the framer sees the latched word while its lo byte goes out, otherwise the live FIFO head
    assign fr_word  = (state == ST_RX_LO) ? word_q : rx_data;
    assign fr_empty = (state == ST_RX_LO) ? wempty_q : rx_empty;
    // overflow is reported on the tx_full bit so a dropped word stays visible until read
    assign status   = status_byte(rx_active, err_flag, rx_empty, tx_full | ovf_flag, STATUS_VERSION);

    coax_spi_word_framer #(.DATA_WIDTH(DATA_WIDTH)) u_framer (
        .word    (fr_word),
        .wempty  (fr_empty),
        .err     (err_flag),
        .tx_hi   (tx_hi_q),
        .tx_lo   (spi_rx_data),
        .hi_byte (hi_byte),
        .lo_byte (lo_byte),
        .tx_word (tx_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            spi_tx_data <= 8'd0;
            rx_read     <= 1'b0;
            tx_load     <= 1'b0;
            tx_data     <= '0;
            soft_reset  <= 1'b0;
            word_q      <= '0;
            wempty_q    <= 1'b1;
            err_flag    <= 1'b0;
            ovf_flag    <= 1'b0;
            tx_hi_q     <= 8'd0;
        end else begin
            rx_read    <= 1'b0;
            tx_load    <= 1'b0;
            soft_reset <= 1'b0;
            err_flag   <= err_flag | rx_error;
            if (spi_cs) begin
                state       <= ST_IDLE;
                spi_tx_data <= 8'd0;
            end else if (spi_rx_strobe) begin
                spi_tx_data <= 8'd0;
                case (state)
                    ST_IDLE: begin
                        case (spi_rx_data)
                            CMD_STATUS: begin
                                spi_tx_data <= status;
                                err_flag    <= rx_error;
                                ovf_flag    <= 1'b0;
                                state       <= ST_STATUS;
                            end
                            CMD_RESET: begin
                                soft_reset <= 1'b1;
                                err_flag   <= rx_error;
                                ovf_flag   <= 1'b0;
                                state      <= ST_DISCARD;
                            end
                            CMD_RX: begin
                                word_q      <= rx_data;
                                wempty_q    <= rx_empty;
                                spi_tx_data <= hi_byte;
                                state       <= ST_RX_LO;
                            end
                            CMD_TX:  state <= ST_TX_HI;
                            default: state <= ST_DISCARD;
                        endcase
                    end
                    ST_RX_HI: begin
                        word_q      <= rx_data;
                        wempty_q    <= rx_empty;
                        spi_tx_data <= hi_byte;
                        state       <= ST_RX_LO;
                    end
                    ST_RX_LO: begin
                        spi_tx_data <= lo_byte;
                        rx_read     <= !wempty_q;
                        state       <= ST_RX_HI;
                    end
                    ST_TX_HI: begin
                        tx_hi_q <= spi_rx_data;
                        state   <= ST_TX_LO;
                    end
                    ST_TX_LO: begin
                        if (tx_full) begin
                            ovf_flag <= 1'b1;
                        end else begin
                            tx_data <= tx_word;
                            tx_load <= 1'b1;
                        end
                        state <= ST_TX_HI;
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coax_spi_control.sv
// tb_coax_spi_control: randomized scoreboard bench; expected bytes and TX words are queued
// by transaction-level stimulus and popped by a monitor as the DUT produces them.
module tb_coax_spi_control;

    logic       clk = 0, reset_n = 0, spi_cs = 1, spi_rx_strobe = 0;
    logic       rx_active = 0, rx_error = 0, rx_empty = 1, tx_full = 0;
    logic [7:0] spi_rx_data = 0, spi_tx_data, spi_tx_data14;
    logic [9:0] rx_data = 0, tx_data;
    logic       rx_read, tx_load, soft_reset;
    logic [13:0] tx_data14;
    logic       rx_read14, tx_load14, soft_reset14;

    int checks = 0, failures = 0;
    int pops = 0, soft_cnt = 0, soft_exp = 0;
    bit err_m = 0, ovf_m = 0, pend = 0;
    logic [7:0] exp_bytes[$];
    logic [9:0] exp_tx[$];
    logic [9:0] fifo[$];
    logic [9:0] snap[$];

    always #5 clk = ~clk;

    coax_spi_control dut (
        .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_rx_data(spi_rx_data),
        .spi_rx_strobe(spi_rx_strobe), .spi_tx_data(spi_tx_data), .rx_active(rx_active),
        .rx_error(rx_error), .rx_data(rx_data), .rx_empty(rx_empty), .rx_read(rx_read),
        .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full), .soft_reset(soft_reset)
    );

    coax_spi_control #(.DATA_WIDTH(14)) u14 (
        .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_rx_data(spi_rx_data),
        .spi_rx_strobe(spi_rx_strobe), .spi_tx_data(spi_tx_data14), .rx_active(1'b0),
        .rx_error(1'b0), .rx_data(14'h2ABC), .rx_empty(1'b0), .rx_read(rx_read14),
        .tx_data(tx_data14), .tx_load(tx_load14), .tx_full(1'b0), .soft_reset(soft_reset14)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void refresh();
        rx_empty = (fifo.size() == 0);
        rx_data  = rx_empty ? 10'd0 : fifo[0];
    endfunction

    // RX FIFO model: pops its head whenever the DUT strobes rx_read
    always @(negedge clk) begin
        if (rx_read) begin
            pops++;
            if (fifo.size() > 0) void'(fifo.pop_front());
            refresh();
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend <= 0;
        else pend <= spi_rx_strobe && !spi_cs;
    end

    // monitor: each accepted strobe yields one byte one cycle later; each tx_load one word
    always @(negedge clk) begin
        if (pend) begin
            if (exp_bytes.size() == 0) check("spi_byte_unexpected", spi_tx_data, 32'hFFFF);
            else check("spi_tx_data", spi_tx_data, exp_bytes.pop_front());
        end
        if (tx_load) begin
            if (exp_tx.size() == 0) check("tx_load_unexpected", tx_load, 0);
            else check("tx_data", tx_data, exp_tx.pop_front());
        end
        if (soft_reset) soft_cnt++;
    end

    function automatic logic [7:0] hi_exp(input int i);
        return (i < snap.size()) ? {1'b0, err_m, 4'b0, snap[i][9:8]} : {1'b1, err_m, 6'b0};
    endfunction

    function automatic logic [7:0] lo_exp(input int i);
        return (i < snap.size()) ? snap[i][7:0] : 8'h00;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        spi_rx_data   = b;
        spi_rx_strobe = 1;
        @(negedge clk);
        spi_rx_strobe = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic begin_txn();
        @(negedge clk);
        spi_cs = 0;
        @(negedge clk);
    endtask

    task automatic end_txn();
        @(negedge clk);
        spi_cs = 1;
        repeat (2) @(negedge clk);
        check("cs_idle_byte", spi_tx_data, 0);
        check("byte_drain", exp_bytes.size(), 0);
        check("tx_drain", exp_tx.size(), 0);
        check("soft_reset_count", soft_cnt, soft_exp);
        exp_bytes.delete();
        exp_tx.delete();
    endtask

    task automatic rx_txn(input int n, input bit chk14);
        int p0 = pops, exp_pops = 0;
        snap = fifo;
        begin_txn();
        exp_bytes.push_back(hi_exp(0));
        send(8'h05);
        if (chk14) check("w14_hi", spi_tx_data14, 8'h2A);
        for (int j = 1; j <= n; j++) begin
            if (j % 2 == 1) begin
                exp_bytes.push_back(lo_exp((j - 1) / 2));
                if ((j - 1) / 2 < snap.size()) exp_pops++;
            end else begin
                exp_bytes.push_back(hi_exp(j / 2));
            end
            send(8'($urandom_range(0, 255)));
            if (chk14 && j == 1) check("w14_lo", spi_tx_data14, 8'hBC);
        end
        end_txn();
        check("rx_pops", pops - p0, exp_pops);
    endtask

    task automatic tx_txn(input int pairs, input logic [7:0] h0, input logic [7:0] l0);
        logic [7:0] h, l;
        begin_txn();
        exp_bytes.push_back(8'h00);
        send(8'h06);
        for (int p = 0; p < pairs; p++) begin
            h = (p == 0) ? h0 : 8'($urandom_range(0, 255));
            l = (p == 0) ? l0 : 8'($urandom_range(0, 255));
            exp_bytes.push_back(8'h00);
            exp_bytes.push_back(8'h00);
            if (tx_full) ovf_m = 1;
            else exp_tx.push_back(10'({h, l}));
            send(h);
            send(l);
        end
        end_txn();
    endtask

    task automatic status_txn(input int extra);
        begin_txn();
        exp_bytes.push_back({rx_active, err_m, fifo.size() == 0, tx_full | ovf_m, 4'h2});
        err_m = 0;
        ovf_m = 0;
        send(8'h01);
        for (int i = 0; i < extra; i++) begin
            exp_bytes.push_back(8'h00);
            send(8'($urandom_range(0, 255)));
        end
        end_txn();
    endtask

    task automatic cmd_txn(input logic [7:0] cmd, input int extra);
        begin_txn();
        exp_bytes.push_back(8'h00);
        if (cmd == 8'h03) begin
            soft_exp++;
            err_m = 0;
            ovf_m = 0;
        end
        send(cmd);
        for (int i = 0; i < extra; i++) begin
            exp_bytes.push_back(8'h00);
            send(8'($urandom_range(0, 255)));
        end
        end_txn();
    endtask

    task automatic pulse_error();
        @(negedge clk);
        rx_error = 1;
        @(negedge clk);
        rx_error = 0;
        err_m = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        int p0;
        repeat (3) @(negedge clk);
        check("reset_spi_tx_data", spi_tx_data, 0);
        check("reset_rx_read", rx_read, 0);
        check("reset_tx_load", tx_load, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_soft_reset", soft_reset, 0);
        reset_n = 1;
        @(negedge clk);

        fifo.push_back(10'h3FF);
        refresh();
        rx_txn(2, 1);
        rx_txn(16, 0);

        tx_txn(1, 8'h02, 8'h5A);
        tx_full = 1;
        tx_txn(1, 8'h02, 8'h5A);
        tx_full = 0;
        status_txn(1);
        status_txn(0);

        pulse_error();
        status_txn(0);
        status_txn(0);

        begin_txn();
        exp_bytes.push_back(8'h00);
        send(8'h06);
        exp_bytes.push_back(8'h00);
        send(8'h7E);
        end_txn();
        fifo.push_back(10'h1C3);
        refresh();
        rx_txn(2, 0);

        cmd_txn(8'h03, 2);
        cmd_txn(8'hA7, 2);

        fifo.push_back(10'h2D5);
        refresh();
        p0 = pops;
        snap = fifo;
        begin_txn();
        exp_bytes.push_back(hi_exp(0));
        send(8'h05);
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        check("async_rst_byte", spi_tx_data, 0);
        check("async_rst_rx_read", rx_read, 0);
        check("async_rst_tx_data", tx_data, 0);
        spi_cs = 1;
        err_m = 0;
        ovf_m = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        check("async_rst_no_pop", pops - p0, 0);
        status_txn(0);

        for (int t = 0; t < 40; t++) begin
            rx_active = 1'($urandom_range(0, 1));
            for (int k = $urandom_range(0, 2); k > 0; k--) fifo.push_back(10'($urandom_range(0, 1023)));
            refresh();
            if ($urandom_range(0, 4) == 0) pulse_error();
            case ($urandom_range(0, 4))
                0: rx_txn($urandom_range(0, 9), 0);
                1: begin
                    tx_full = 1'($urandom_range(0, 1));
                    tx_txn($urandom_range(1, 3), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                end
                2: status_txn($urandom_range(0, 2));
                3: cmd_txn(8'h03, $urandom_range(0, 2));
                default: begin
                    do c = 8'($urandom_range(0, 255));
                    while (c == 8'h01 || c == 8'h03 || c == 8'h05 || c == 8'h06);
                    cmd_txn(c, $urandom_range(0, 3));
                end
            endcase
        end
        tx_full = 0;
        status_txn(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
